layer_mac_engine: RTL and testbench

- Computes one fully connected layer's pre-activation vector, out[j] = sum_i W[j][i]*x[i] + b[j], using one multiplier time-shared over all weights.
- Sits directly upstream of the ReLU/negative-filter stage; its output_vector feeds that stage unchanged.
- Weights are read from an external synchronous ROM/BRAM with 1-cycle read latency.

---
 rtl/layer_mac_engine.sv | 179 +++++++++++++++++
 tb/tb_layer_mac_engine.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/layer_mac_engine.sv
// layer_mac_engine: one fully connected layer's pre-activation vector,
//   out[j] = sum_i W[j][i]*x[i] + b[j]
// using a single time-shared multiplier. Weights come from an external
// synchronous memory with one cycle of read latency.
// Build option: define MAC_SATURATE_EN to clamp each result to the signed
// DATA_W range; without it the low DATA_W bits are kept (two's-complement wrap).
`ifndef MAX_NEURONS
`define MAX_NEURONS 4
`endif

module layer_mac_engine #(
  parameter int N      = `MAX_NEURONS,
  parameter int DATA_W = 16,
  parameter int FRAC   = 8,
  parameter int ADDR_W = $clog2(N*N)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [$clog2(N+1)-1:0]  n_in,
  input  logic [$clog2(N+1)-1:0]  n_out,
  input  logic [N*DATA_W-1:0]     input_vector,
  input  logic [N*DATA_W-1:0]     bias_vector,
  output logic                    w_rd_en,
  output logic [ADDR_W-1:0]       w_addr,
  input  logic [DATA_W-1:0]       w_data,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [N*DATA_W-1:0]     output_vector
);

  localparam int CNT_W = $clog2(N+1);
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int ACC_W = 2*DATA_W + $clog2(N) + 1;

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ISSUE, WRITE, DONE} state_t;

  state_t                  state;
  logic [CNT_W-1:0]        n_in_q, n_out_q;
  logic [IDX_W-1:0]        i_idx, j_idx, i_prev;
  logic                    rd_pend;
  logic [ADDR_W-1:0]       row_base;
  logic signed [ACC_W-1:0] acc;
  logic [DATA_W-1:0]       x_q [N];
  logic [DATA_W-1:0]       b_q [N];

  logic                    accept, illegal, last_i, last_j;
  logic [DATA_W-1:0]       x_sel, b_sel;
  logic signed [2*DATA_W-1:0] w_ext, x_ext, prod;
  logic signed [ACC_W-1:0] prod_ext, bias_scaled, final_sum, shifted;
  logic [DATA_W-1:0]       lane_result;

  assign accept  = (state == IDLE) && start;
  assign illegal = (n_in == '0) || (n_in > CNT_W'(N)) || (n_out == '0) || (n_out > CNT_W'(N));
  assign last_i  = (CNT_W'(i_idx) == n_in_q - CNT_W'(1));
  assign last_j  = (CNT_W'(j_idx) == n_out_q - CNT_W'(1));

  // Latch the operand vectors when a computation is accepted.
  // NOTE: operand storage has no reset; it is never read before a start reloads it.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int k = 0; k < N; k++) begin
        x_q[k] <= input_vector[k*DATA_W +: DATA_W];
        b_q[k] <= bias_vector[k*DATA_W +: DATA_W];
      end
    end
  end

  // Shared multiplier and row finalisation: product of the returned weight
  // with the element issued one cycle earlier, plus scaled bias and narrowing.
  // NOTE: every always_comb output is given a default first so no latch is inferred.
  always_comb begin
    x_sel       = x_q[i_prev];
    b_sel       = b_q[j_idx];
    w_ext       = {{DATA_W{w_data[DATA_W-1]}}, w_data};
    x_ext       = {{DATA_W{x_sel[DATA_W-1]}}, x_sel};
    prod        = w_ext * x_ext;
    prod_ext    = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
    bias_scaled = {{(ACC_W-DATA_W-FRAC){b_sel[DATA_W-1]}}, b_sel, {FRAC{1'b0}}};
    final_sum   = acc + prod_ext + bias_scaled;
    shifted     = final_sum >>> FRAC;
    lane_result = shifted[DATA_W-1:0];
`ifdef MAC_SATURATE_EN
    if (shifted > SAT_MAX) begin
      lane_result = SAT_MAX[DATA_W-1:0];
    end else if (shifted < SAT_MIN) begin
      lane_result = SAT_MIN[DATA_W-1:0];
    end
`endif
  end

  // Control FSM with registered outputs: issue one weight read per cycle,
  // accumulate the returning products, write one lane per row.
  // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      w_rd_en       <= 1'b0;
      w_addr        <= '0;
      output_vector <= '0;
      i_idx         <= '0;
      j_idx         <= '0;
      i_prev        <= '0;
      acc           <= '0;
      rd_pend       <= 1'b0;
      row_base      <= '0;
      n_in_q        <= '0;
      n_out_q       <= '0;
    end else begin
      done    <= 1'b0;
      rd_pend <= w_rd_en;
      i_prev  <= i_idx;
      case (state)
        IDLE: begin
          if (start) begin
            n_in_q        <= n_in;
            n_out_q       <= n_out;
            output_vector <= '0;
            i_idx         <= '0;
            j_idx         <= '0;
            acc           <= '0;
            row_base      <= '0;
            w_addr        <= '0;
            busy          <= 1'b1;
            if (illegal) begin
              err   <= 1'b1;
              state <= DONE;
            end else begin
              err     <= 1'b0;
              w_rd_en <= 1'b1;
              state   <= ISSUE;
            end
          end
        end
        ISSUE: begin
          // The first issue of a row has no weight in flight yet.
          if (rd_pend) begin
            acc <= acc + prod_ext;
          end
          if (last_i) begin
            w_rd_en <= 1'b0;
            state   <= WRITE;
          end else begin
            i_idx  <= i_idx + IDX_W'(1);
            w_addr <= w_addr + ADDR_W'(1);
          end
        end
        WRITE: begin
          output_vector[int'(j_idx)*DATA_W +: DATA_W] <= lane_result;
          acc   <= '0;
          i_idx <= '0;
          if (last_j) begin
            state <= DONE;
          end else begin
            j_idx    <= j_idx + IDX_W'(1);
            row_base <= row_base + ADDR_W'(N);
            w_addr   <= row_base + ADDR_W'(N);
            w_rd_en  <= 1'b1;
            state    <= ISSUE;
          end
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_layer_mac_engine.sv
// Testbench for layer_mac_engine (N=4, DATA_W=16, FRAC=8) with a synchronous
// weight memory model and an arithmetic reference of the layer equation.
`timescale 1ns/1ps

module tb_layer_mac_engine;

  localparam int N      = 4;
  localparam int DATA_W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [2:0]        n_in, n_out;
  logic [N*DATA_W-1:0] input_vector, bias_vector;
  logic              w_rd_en;
  logic [3:0]        w_addr;
  logic [DATA_W-1:0] w_data;
  logic              busy, done, err;
  logic [N*DATA_W-1:0] output_vector;

  logic [15:0] wmem [16];
  logic [15:0] x_m  [4];
  logic [15:0] b_m  [4];

  int tests = 0;
  int fails = 0;

  layer_mac_engine #(.N(N), .DATA_W(DATA_W), .FRAC(8), .ADDR_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .n_in(n_in), .n_out(n_out),
    .input_vector(input_vector), .bias_vector(bias_vector),
    .w_rd_en(w_rd_en), .w_addr(w_addr), .w_data(w_data),
    .busy(busy), .done(done), .err(err), .output_vector(output_vector)
  );

  always #5 clk = ~clk;

  // Weight memory: data appears one cycle after the read strobe.
  always @(posedge clk) begin
    if (w_rd_en) w_data <= wmem[w_addr];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: exact integer dot product, scaled bias, floor shift, then narrow.
  function automatic logic [15:0] model_lane(input int j, input int nin);
    longint s = 0;
    for (int i = 0; i < nin; i++)
      s += longint'($signed(wmem[j*4+i])) * longint'($signed(x_m[i]));
    s += longint'($signed(b_m[j])) * 256;
    s = s >>> 8;
`ifdef MAC_SATURATE_EN
    if (s > 32767) s = 32767;
    else if (s < -32768) s = -32768;
`endif
    return 16'(s);
  endfunction

  task automatic rand_data();
    for (int k = 0; k < 16; k++) wmem[k] = 16'($urandom);
    for (int k = 0; k < 4; k++) begin
      x_m[k] = 16'($urandom);
      b_m[k] = 16'($urandom);
    end
  endtask

  task automatic drive_start(input int nin, input int nout);
    @(negedge clk);
    n_in  = 3'(nin);
    n_out = 3'(nout);
    for (int k = 0; k < 4; k++) begin
      input_vector[k*16 +: 16] = x_m[k];
      bias_vector[k*16 +: 16]  = b_m[k];
    end
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic check_outputs(input string tag, input int nin, input int nout, input bit exp_err);
    for (int j = 0; j < 4; j++)
      check($sformatf("%s out[%0d]", tag, j), output_vector[j*16 +: 16],
            (exp_err || j >= nout) ? 16'h0000 : model_lane(j, nin));
  endtask

  // One layer run; inject_at >= 0 pulses a conflicting start at that cycle.
  task automatic run_layer(input string tag, input int nin, input int nout, input int inject_at);
    logic [3:0] addr_q[$];
    int exp_addr[$];
    int cyc;
    bit got;
    bit exp_err;
    exp_err = (nin == 0 || nin > 4 || nout == 0 || nout > 4);
    if (!exp_err)
      for (int j = 0; j < nout; j++)
        for (int i = 0; i < nin; i++) exp_addr.push_back(j*4 + i);
    drive_start(nin, nout);
    check({tag, " busy"}, busy, 1'b1);
    cyc = 0;
    got = 1'b0;
    while (!got && cyc <= 200) begin
      if (w_rd_en) addr_q.push_back(w_addr);
      if (done) got = 1'b1;
      else begin
        start = (cyc == inject_at);
        if (start) begin
          n_in = 3'd1;
          n_out = 3'd1;
          input_vector = {$urandom(), $urandom()};
        end
        @(posedge clk);
        #1;
        cyc++;
      end
    end
    start = 1'b0;
    check({tag, " done seen"}, got, 1'b1);
    check({tag, " done cycle"}, cyc, exp_err ? 1 : nout*(nin+1)+1);
    check({tag, " err"}, err, exp_err);
    check({tag, " addr count"}, addr_q.size(), exp_addr.size());
    for (int k = 0; k < addr_q.size() && k < exp_addr.size(); k++)
      check($sformatf("%s addr[%0d]", tag, k), addr_q[k], exp_addr[k]);
    check_outputs(tag, nin, nout, exp_err);
    @(posedge clk);
    #1;
    check({tag, " done pulse"}, done, 1'b0);
    check({tag, " busy idle"}, busy, 1'b0);
    check_outputs({tag, " hold"}, nin, nout, exp_err);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    n_in = '0;
    n_out = '0;
    input_vector = '0;
    bias_vector = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset err", err, 1'b0);
    check("reset rd_en", w_rd_en, 1'b0);
    check("reset addr", w_addr, 4'h0);
    check("reset out", output_vector, 64'h0);
    @(negedge clk);
    rst = 1'b0;

    // Identity weights pass x straight through.
    for (int k = 0; k < 16; k++) wmem[k] = (k % 5 == 0) ? 16'h0100 : 16'h0000;
    x_m = '{16'h0100, 16'h0200, 16'hFF00, 16'h0080};
    b_m = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
    run_layer("ident", 4, 4, -1);
    check("ident vector", output_vector, 64'h0080_FF00_0200_0100);

    // Bias, including a negative lane that must be passed unchanged.
    for (int k = 0; k < 16; k++) wmem[k] = 16'h0100;
    x_m = '{16'h0100, 16'h0100, 16'h0100, 16'h0100};
    b_m = '{16'h0000, 16'hFB00, 16'h0080, 16'h0000};
    run_layer("bias", 4, 4, -1);
    check("bias vector", output_vector, 64'h0400_0480_FF00_0400);

    // Partial size.
    rand_data();
    run_layer("partial", 2, 3, -1);

    // Overflow of the narrowed result.
    for (int k = 0; k < 16; k++) wmem[k] = 16'h7FFF;
    x_m = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
    b_m = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
    run_layer("ovf", 4, 4, -1);
`ifdef MAC_SATURATE_EN
    check("ovf lane0", output_vector[15:0], 16'h7FFF);
`else
    check("ovf lane0", output_vector[15:0], 16'hFC00);
`endif

    // Illegal sizes: error flag, cleared outputs, no weight reads.
    run_layer("bad n_in", 0, 4, -1);
    repeat (3) @(posedge clk);
    #1;
    check("err held", err, 1'b1);
    run_layer("bad n_out", 4, 5, -1);
    rand_data();
    run_layer("after err", 3, 2, -1);

    // Start while busy is ignored.
    rand_data();
    run_layer("busy start", 4, 4, 7);

    // Reset in the middle of a row aborts at once.
    rand_data();
    drive_start(4, 4);
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst busy", busy, 1'b0);
    check("midrst out", output_vector, 64'h0);
    check("midrst rd_en", w_rd_en, 1'b0);
    check("midrst done", done, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    run_layer("post rst", 4, 4, -1);

    // Random sizes and data.
    for (int t = 0; t < 6; t++) begin
      rand_data();
      run_layer($sformatf("rand%0d", t), int'($urandom_range(1, 4)), int'($urandom_range(1, 4)), -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
